// File: rtl/relm_i2c_pkg.sv
// Shared definitions for the ReLM I2C target: state encoding, ACK levels, default address.
package relm_i2c_pkg;

  localparam logic [6:0] DEFAULT_ADDR = 7'h39;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_ADDR     = 4'd1;
  localparam state_t ST_ADDR_ACK = 4'd2;
  localparam state_t ST_PTR      = 4'd3;
  localparam state_t ST_PTR_ACK  = 4'd4;
  localparam state_t ST_WDAT     = 4'd5;
  localparam state_t ST_WDAT_ACK = 4'd6;
  localparam state_t ST_RDAT     = 4'd7;
  localparam state_t ST_RDAT_ACK = 4'd8;

endpackage

// File: rtl/relm_i2c_filter.sv
// SCL/SDA synchronizer, glitch filter and bus event detector; both lines share one sample
// so START/STOP are judged against the same SCL level.
module relm_i2c_filter
  import relm_i2c_pkg::*;
#(
  parameter int FILT = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic sclr_o,
  output logic sclf_o,
  output logic start_o,
  output logic stop_o
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  // Bit 0 is SCL, bit 1 is SDA.
  logic [1:0]    meta_q, sync_q, filt_q, prev_q;
  logic [CW-1:0] cnt_q [2];

  // A filtered level only follows the pin after FILT consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q   <= '1;
      sync_q   <= '1;
      filt_q   <= '1;
      prev_q   <= '1;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      meta_q <= {sda_i, scl_i};
      sync_q <= meta_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT - 1)) begin
          filt_q[i] <= sync_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign sda_o   = filt_q[1];
  assign sclr_o  =  filt_q[0] & ~prev_q[0];
  assign sclf_o  = ~filt_q[0] &  prev_q[0];
  assign start_o =  prev_q[1] & ~filt_q[1] & filt_q[0] & prev_q[0];
  assign stop_o  = ~prev_q[1] &  filt_q[1] & filt_q[0] & prev_q[0];

endmodule

// File: rtl/relm_i2c_target.sv
// I2C target exposing a byte register bank with an auto-incrementing pointer; the ReLM core
// shares the bank through a host port.
module relm_i2c_target
  import relm_i2c_pkg::*;
#(
  parameter logic [6:0] ADDR = DEFAULT_ADDR,
  parameter int         WRA  = 4,
  parameter int         FILT = 3
) (
  input  logic           clk,
  input  logic           rst_n_in,
  input  logic           scl_in,
  input  logic           sda_in,
  output logic           sda_oe_out,
  input  logic           reg_we_in,
  input  logic [WRA-1:0] reg_wa_in,
  input  logic [7:0]     reg_d_in,
  input  logic [WRA-1:0] reg_ra_in,
  output logic [7:0]     reg_q_out,
  output logic           wr_strobe_out,
  output logic [WRA-1:0] wr_addr_out,
  output logic [7:0]     wr_data_out,
  output logic           busy_out
);

  logic sdaF, sclr, sclf, startDet, stopDet;

  relm_i2c_filter #(.FILT(FILT)) uFilter (
    .clk_i   (clk),
    .rst_n_i (rst_n_in),
    .scl_i   (scl_in),
    .sda_i   (sda_in),
    .sda_o   (sdaF),
    .sclr_o  (sclr),
    .sclf_o  (sclf),
    .start_o (startDet),
    .stop_o  (stopDet)
  );

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [7:0]     rx_q, rx_d, tx_q, tx_d;
  logic [WRA-1:0] ptr_q, ptr_d;
  logic           oe_q, oe_d, busy_q, busy_d, wrStb_q, wrStb_d;
  logic [WRA-1:0] wrAddr_q, wrAddr_d;
  logic [7:0]     wrData_q, wrData_d, regQ_q;
  logic           busWe;
  logic [7:0]     bank_q [2**WRA];
  logic [7:0]     bankPtr;

  assign bankPtr = bank_q[ptr_q];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    wrStb_d  = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    busWe    = 1'b0;
    if (startDet) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (stopDet) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDAT: begin
          if (sclr && cnt_q != 4'd8) begin
            rx_d  = {rx_q[6:0], sdaF};
            cnt_d = cnt_q + 4'd1;
          end else if (sclf && cnt_q == 4'd8) begin
            if (state_q == ST_ADDR) begin
              if (rx_q[7:1] == ADDR) begin
                oe_d    = 1'b1;
                state_d = ST_ADDR_ACK;
              end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
              end
            end else if (state_q == ST_PTR) begin
              ptr_d   = rx_q[WRA-1:0];
              oe_d    = 1'b1;
              state_d = ST_PTR_ACK;
            end else begin
              busWe    = 1'b1;
              wrStb_d  = 1'b1;
              wrAddr_d = ptr_q;
              wrData_d = rx_q;
              ptr_d    = ptr_q + 1'b1;
              oe_d     = 1'b1;
              state_d  = ST_WDAT_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (sclf) begin
            busy_d = 1'b1;
            cnt_d  = 4'd0;
            oe_d   = 1'b0;
            state_d = ST_PTR;
            if (rx_q[0]) begin
              tx_d    = {bankPtr[6:0], 1'b0};
              oe_d    = ~bankPtr[7];
              cnt_d   = 4'd1;
              state_d = ST_RDAT;
            end
          end
        end
        ST_PTR_ACK, ST_WDAT_ACK: begin
          if (sclf) begin
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
            state_d = ST_WDAT;
          end
        end
        ST_RDAT: begin
          // cnt counts bits already presented; the 8th falling edge ends the byte.
          if (sclf) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              ptr_d   = ptr_q + 1'b1;
              state_d = ST_RDAT_ACK;
            end else begin
              oe_d  = ~tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ST_RDAT_ACK: begin
          if (sclr && sdaF == NACK) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else if (sclf) begin
            tx_d    = {bankPtr[6:0], 1'b0};
            oe_d    = ~bankPtr[7];
            cnt_d   = 4'd1;
            state_d = ST_RDAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      wrStb_q  <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      regQ_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      wrStb_q  <= wrStb_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      regQ_q   <= bank_q[reg_ra_in];
    end
  end

  // Bank survives reset; the bus write is issued last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (reg_we_in) bank_q[reg_wa_in] <= reg_d_in;
    if (busWe && rst_n_in) bank_q[ptr_q] <= rx_q;
  end

  assign sda_oe_out    = oe_q;
  assign busy_out      = busy_q;
  assign wr_strobe_out = wrStb_q;
  assign wr_addr_out   = wrAddr_q;
  assign wr_data_out   = wrData_q;
  assign reg_q_out     = regQ_q;

endmodule

// File: tb/tb_relm_i2c_target.sv
// Scoreboard bench for relm_i2c_target: a bus-master model drives frames while monitors
// compare write strobes and read bytes against a register-bank model.
module tb_relm_i2c_target;

  localparam int WRA = 4;
  localparam int Q   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, sclDrv, sdaDrv, sdaBus;
  logic           sdaOe, regWe, wrStb, busy;
  logic [WRA-1:0] regWa, regRa, wrAddr;
  logic [7:0]     regD, regQ, wrData;

  assign sdaBus = sdaDrv & ~sdaOe;

  relm_i2c_target #(.ADDR(7'h39), .WRA(WRA), .FILT(3)) dut (
    .clk           (clk),
    .rst_n_in      (rst_n),
    .scl_in        (sclDrv),
    .sda_in        (sdaBus),
    .sda_oe_out    (sdaOe),
    .reg_we_in     (regWe),
    .reg_wa_in     (regWa),
    .reg_d_in      (regD),
    .reg_ra_in     (regRa),
    .reg_q_out     (regQ),
    .wr_strobe_out (wrStb),
    .wr_addr_out   (wrAddr),
    .wr_data_out   (wrData),
    .busy_out      (busy)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model [16];
  logic [11:0] wrQ [$];
  logic [7:0]  rdQ [$];
  logic [7:0]  rdGot;
  logic [11:0] expWr;
  logic        oeSeen;
  event        rdDone;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic scl, input logic sda, input int n);
    sclDrv = scl;
    sdaDrv = sda;
    waitCycles(n);
  endtask

  task automatic i2cStart();
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic repStart();
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b0, 1'b0, Q);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b0, Q);
    applyStimulus(1'b1, 1'b0, Q);
    applyStimulus(1'b1, 1'b1, Q);
  endtask

  // Glitch mode adds a 1-cycle SCL pulse while low and a 1-cycle SDA flip while high.
  task automatic writeBit(input logic b, input logic glitch);
    if (glitch) begin
      applyStimulus(1'b0, b, Q/2);
      applyStimulus(1'b1, b, 1);
      applyStimulus(1'b0, b, Q/2 - 1);
      applyStimulus(1'b1, b, Q);
      applyStimulus(1'b1, ~b, 1);
      applyStimulus(1'b1, b, Q - 1);
    end else begin
      applyStimulus(1'b0, b, Q);
      applyStimulus(1'b1, b, 2*Q);
    end
    applyStimulus(1'b0, b, Q);
  endtask

  task automatic readBit(output logic b);
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, Q);
    b = sdaBus;
    applyStimulus(1'b1, 1'b1, Q);
    applyStimulus(1'b0, 1'b1, Q);
  endtask

  task automatic writeByte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i], glitch);
    readBit(ack);
  endtask

  task automatic readByte(input logic masterAck);
    logic [7:0] d;
    logic       b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      d = {d[6:0], b};
    end
    rdGot = d;
    ->rdDone;
    writeBit(masterAck, 1'b0);
  endtask

  task automatic busWrite(input logic [7:0] ptr, input logic [7:0] data[$], input logic glitch);
    logic ack;
    int   p;
    p = ptr % 16;
    i2cStart();
    writeByte(8'h72, 1'b0, ack);
    checkOutput("write address ack", ack, 0);
    writeByte(ptr, 1'b0, ack);
    checkOutput("pointer ack", ack, 0);
    checkOutput("busy during write", busy, 1);
    foreach (data[i]) begin
      wrQ.push_back({4'(p), data[i]});
      model[p] = data[i];
      writeByte(data[i], glitch, ack);
      checkOutput("data ack", ack, 0);
      p = (p + 1) % 16;
    end
    i2cStop();
    waitCycles(Q);
    checkOutput("busy after stop", busy, 0);
  endtask

  task automatic busRead(input logic [7:0] ptr, input int n);
    logic ack;
    i2cStart();
    writeByte(8'h72, 1'b0, ack);
    checkOutput("read setup address ack", ack, 0);
    writeByte(ptr, 1'b0, ack);
    checkOutput("read setup pointer ack", ack, 0);
    repStart();
    writeByte(8'h73, 1'b0, ack);
    checkOutput("read address ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      rdQ.push_back(model[(ptr + i) % 16]);
      readByte(i == n - 1);
    end
    checkOutput("sda released after nack", sdaOe, 0);
    checkOutput("busy after nack", busy, 0);
    i2cStop();
  endtask

  task automatic hostWrite(input int a, input logic [7:0] d);
    regWa = WRA'(a);
    regD  = d;
    regWe = 1'b1;
    waitCycles(1);
    regWe = 1'b0;
    model[a] = d;
  endtask

  task automatic hostCheck(input int a);
    regRa = WRA'(a);
    waitCycles(2);
    checkOutput("host read", regQ, model[a]);
  endtask

  always @(negedge clk) begin
    if (sdaOe) oeSeen = 1'b1;
    if (rst_n && wrStb) begin
      if (wrQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected wr_strobe: got addr 0x%0h data 0x%0h, required no strobe", wrAddr, wrData);
      end else begin
        expWr = wrQ.pop_front();
        checkOutput("wr_strobe addr/data", {wrAddr, wrData}, expWr);
      end
    end
  end

  always @(rdDone) begin
    if (rdQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected read byte: got 0x%0h, required none", rdGot);
    end else begin
      checkOutput("bus read byte", rdGot, rdQ.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] dq [$];
    logic       ack, seen;
    rst_n = 1'b0; sclDrv = 1'b1; sdaDrv = 1'b1;
    regWe = 1'b0; regWa = '0; regD = '0; regRa = '0;
    oeSeen = 1'b0;
    waitCycles(3);
    checkOutput("reset sda_oe", sdaOe, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wr_strobe", wrStb, 0);
    checkOutput("reset wr_addr/data", {wrAddr, wrData}, 0);
    checkOutput("reset reg_q", regQ, 0);
    rst_n = 1'b1;
    waitCycles(2);
    for (int a = 0; a < 16; a++) hostWrite(a, 8'($urandom));

    // Basic write frame with auto-increment.
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h5A);
    busWrite(8'h03, dq, 1'b0);
    hostCheck(3);
    hostCheck(4);

    // Read with repeated START and pointer wrap.
    hostWrite(15, 8'h11);
    hostWrite(0, 8'h22);
    busRead(8'h0F, 2);

    // Wrong address: never acknowledged, nothing written.
    oeSeen = 1'b0;
    i2cStart();
    writeByte(8'h74, 1'b0, ack);
    checkOutput("wrong address nack", ack, 1);
    writeByte(8'h03, 1'b0, ack);
    checkOutput("ignored byte nack", ack, 1);
    i2cStop();
    checkOutput("sda driven during wrong address", oeSeen, 0);

    // Glitches during the data phase.
    dq.delete(); dq.push_back(8'h3C); dq.push_back(8'hC3);
    busWrite(8'h08, dq, 1'b1);
    hostCheck(8);
    hostCheck(9);

    // Host and bus write to address 5 in the same cycle.
    dq.delete(); dq.push_back(8'hEE);
    fork
      busWrite(8'h05, dq, 1'b0);
      begin
        seen = 1'b0;
        regWa = 4'd5; regD = 8'h00; regWe = 1'b1;
        for (int k = 0; k < 3000 && !seen; k++) begin
          waitCycles(1);
          seen = wrStb;
        end
        regWe = 1'b0;
        if (!seen) begin
          checks++;
          errors++;
          $display("[TB] FAIL collision strobe timeout: got none, required wr_strobe");
        end
      end
    join
    hostCheck(5);

    // Randomized writes and reads against the model.
    for (int t = 0; t < 3; t++) begin
      dq.delete();
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) dq.push_back(8'($urandom));
      busWrite(8'($urandom), dq, 1'b0);
    end
    for (int t = 0; t < 3; t++) busRead(8'($urandom), int'($urandom_range(1, 3)));
    for (int t = 0; t < 4; t++) hostCheck(int'($urandom_range(0, 15)));

    // Reset while the target drives a 0 data bit.
    hostWrite(7, 8'h00);
    i2cStart();
    writeByte(8'h72, 1'b0, ack);
    writeByte(8'h07, 1'b0, ack);
    repStart();
    writeByte(8'h73, 1'b0, ack);
    checkOutput("target driving read bit", sdaOe, 1);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("sda_oe after mid-read reset", sdaOe, 0);
    checkOutput("busy after mid-read reset", busy, 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, Q);
    applyStimulus(1'b1, 1'b1, 2*Q);
    dq.delete(); dq.push_back(8'h96); dq.push_back(8'h69);
    busWrite(8'h0E, dq, 1'b0);
    hostCheck(14);
    hostCheck(15);

    waitCycles(Q);
    checkOutput("write scoreboard drained", wrQ.size(), 0);
    checkOutput("read scoreboard drained", rdQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relm_i2c_target.md
Name: relm_i2c_target

Overview:
- I2C target (responder) for a board-level I2C bus. It is the counterpart of the ReLM bit-banged I2C initiator on the same SCL/SDA pair.
- Exposes a byte-wide register bank to the bus with an auto-incrementing register pointer. The ReLM core can read and write the same bank through a host port.
- Used for self-test of the initiator firmware and for peer-board configuration links.
- Runs entirely in the system clock domain. SCL/SDA are oversampled; the block never stretches SCL.

Parameters:
- ADDR, 7'h39, 7-bit target address this block answers to.
- WRA, 4, register pointer width; bank depth is 2**WRA bytes.
- FILT, 3, number of consecutive equal samples needed before a filtered SCL/SDA level changes (glitch filter).

Ports:
- clk  in  1  system clock
- rst_n_in  in  1  synchronous active-low reset
- scl_in  in  1  raw SCL pin level
- sda_in  in  1  raw SDA pin level
- sda_oe_out  out  1  1 = pull SDA low; top level maps this to open-drain
- reg_we_in  in  1  host write strobe
- reg_wa_in  in  WRA  host write address
- reg_d_in  in  8  host write data
- reg_ra_in  in  WRA  host read address
- reg_q_out  out  8  host read data, 1-cycle latency
- wr_strobe_out  out  1  1-cycle pulse when a bus write commits a byte
- wr_addr_out  out  WRA  bank address of the committed byte
- wr_data_out  out  8  committed byte
- busy_out  out  1  1 from an addressed START until STOP or NACK

Behaviour:
- Reset (rst_n_in=0 at a clk edge):
  - sda_oe_out=0, wr_strobe_out=0, busy_out=0, wr_addr_out=0, wr_data_out=0, reg_q_out=0.
  - State=IDLE, pointer=0, filters preset to 1.
  - Bank contents are NOT cleared.
  - Reset asserted mid-transfer releases SDA in the same cycle its effect is registered.
- Input path:
  - 2-FF synchronizer, then the FILT-sample filter.
  - Edges are detected on the filtered signals: sclr/sclf (SCL rising/falling), start = SDA falling while SCL high, stop = SDA rising while SCL high.
  - START/STOP take precedence over bit handling in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK.
  - start from any state (including a repeated START): go to ADDR, bit counter=0, release SDA. The pointer is kept.
  - stop from any state: go to IDLE, release SDA, busy_out=0.
  - ADDR: shift SDA in MSB first on each sclr; after 8 bits, on the next sclf:
    - address match: drive ACK (sda_oe_out=1), go to ADDR_ACK.
    - mismatch: go to IDLE and ignore the bus until the next start.
  - ADDR_ACK: on the next sclf, release SDA and set busy_out=1.
    - R/W=0: go to PTR.
    - R/W=1: load shift register from bank[pointer], drive its MSB (oe=~bit), go to RDAT.
  - PTR: 8 bits received; on sclf, pointer <= byte[WRA-1:0] (upper bits ignored), ACK, go to PTR_ACK.
  - PTR_ACK: release on the next sclf, go to WDAT.
  - WDAT: 8 bits received; on the following sclf:
    - write bank[pointer], pulse wr_strobe_out with wr_addr_out=pointer and wr_data_out=byte.
    - pointer+1 mod 2**WRA; ACK; go to WDAT_ACK.
  - WDAT_ACK: release on the next sclf, go to WDAT.
  - RDAT: the next bit is presented on each sclf. After the 8th bit's sclf, release SDA, pointer+1 mod 2**WRA, go to RDAT_ACK.
  - RDAT_ACK: sample SDA on sclr.
    - ACK (0): on sclf load bank[pointer] and drive its MSB, go to RDAT.
    - NACK (1): go to IDLE, busy_out=0, SDA stays released.
- SDA changes only on filtered sclf, never while filtered SCL is high.
- Host port:
  - reg_q_out <= bank[reg_ra_in] every cycle.
  - A host write and a bus write to the same address in the same cycle: the bus write wins.
  - A host write to the address being shifted out does not alter the byte already loaded.
- Pointer wrap: 2**WRA-1 increments to 0 with no error indication.

Decomposition:
- Shared package (relm_i2c_pkg): state encoding enum, ACK/NACK constants, default ADDR.
- One sub-module, relm_i2c_filter: synchronizer plus FILT glitch filter plus edge/START/STOP detect. Instantiated once, covering SCL and SDA together so the START/STOP relation is evaluated on a common sample.
- The bank is inferred inside the top module (MLAB-sized).

Test Plan:
- Write: START, 0x72 (0x39,W), ptr 0x03, data 0xA5, 0x5A, STOP -> ACK on all 4 bytes; wr_strobe_out pulses with (3,0xA5) then (4,0x5A); host read of 3/4 returns A5/5A; busy_out falls after STOP.
- Read with repeated START: host preloads bank[0xF]=0x11, bank[0x0]=0x22. START, 0x72, ptr 0x0F, Sr, 0x73, read, master ACK, read, master NACK, STOP -> bus returns 0x11, 0x22 (pointer wraps); SDA released after NACK.
- Wrong address: START, 0x74 -> no ACK (sda_oe_out stays 0 for the whole frame); no wr_strobe_out; state IDLE until the next START.
- Glitch rejection: inject 1-cycle SCL and SDA pulses (< FILT) during the data phase -> no bit shift, no false START/STOP; the transfer completes with the correct data.
- Collision: host write of 0x00 to addr 5 in the same cycle as a bus write of 0xEE to addr 5 -> bank[5]=0xEE.
- Reset mid-read while driving 0 -> sda_oe_out=0 after that edge; busy_out=0; the next full write transaction succeeds.
